hazard_ctrl_param: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the IF/ID register. It detects load-use hazards and inserts a configurable number of bubbles, and it sequences jumps and branches with configurable branch-resolution latency and beq/bne polarity. It freezes the whole front end on a memory-stall request and keeps a saturating count of cycles in which the PC was held.

---
 rtl/hazard_ctrl_param_if.sv | 36 +++
 rtl/hazard_ctrl_param.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl_param.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_param_if.sv
// Decode-stage hazard bus between the MIPS ID/EX datapath and hazard_ctrl_param.
// master = pipeline side (drives decode info), slave = hazard controller.
interface hazard_ctrl_param_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             Jump;
  logic             Branch;
  logic             BranchNe;
  logic             ALUZero;
  logic             memReadEX;
  logic [REG_W-1:0] currRs;
  logic [REG_W-1:0] currRt;
  logic [REG_W-1:0] prevRt;
  logic             UseShamt;
  logic             UseImmed;
  logic             MemStall;
  logic             StatClr;
  logic             IF_write;
  logic             PC_write;
  logic             bubble;
  logic [1:0]       addrSel;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output Jump, Branch, BranchNe, ALUZero, memReadEX,
    output currRs, currRt, prevRt, UseShamt, UseImmed, MemStall, StatClr,
    input  IF_write, PC_write, bubble, addrSel, StallCount
  );

  modport slave (
    input  Jump, Branch, BranchNe, ALUZero, memReadEX,
    input  currRs, currRt, prevRt, UseShamt, UseImmed, MemStall, StatClr,
    output IF_write, PC_write, bubble, addrSel, StallCount
  );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Load-use / branch / jump hazard controller with configurable stall lengths,
// global memory-stall freeze and a saturating PC-held cycle counter.
module hazard_ctrl_param #(
  parameter int REG_W       = 5,
  parameter int LOAD_STALLS = 1,
  parameter int BR_RESOLVE  = 1,
  parameter int CNT_W       = 16
) (
  input logic                Clk,
  input logic                Rst,
  hazard_ctrl_param_if.slave hz
);

  typedef enum logic [2:0] {
    NORMAL   = 3'd0,
    LOAD     = 3'd1,
    BR_WAIT  = 3'd2,
    BR_TAKEN = 3'd3,
    JUMP     = 3'd4
  } state_e;

  // {IF_write, PC_write, bubble, addrSel[1:0]}
  localparam logic [4:0] OUT_DEF  = 5'b11000;
  localparam logic [4:0] OUT_HOLD = 5'b00100;
  localparam logic [4:0] OUT_BRH  = 5'b10000;
  localparam logic [4:0] OUT_JMP  = 5'b01101;
  localparam logic [4:0] OUT_TKN  = 5'b01110;
  localparam logic [4:0] OUT_FRZ  = 5'b00000;

  localparam logic [2:0] LD_INIT = 3'(LOAD_STALLS - 1);
  localparam logic [2:0] BR_INIT = 3'(BR_RESOLVE - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             brne_q, brne_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]       ctl_s;
  logic             rt_used_s;
  logic             ld_hazard_s;

  assign rt_used_s   = ~hz.UseShamt & ~hz.UseImmed;
  assign ld_hazard_s = hz.memReadEX & (hz.prevRt != {REG_W{1'b0}}) &
                       ((hz.currRs == hz.prevRt) | (rt_used_s & (hz.currRt == hz.prevRt)));

  // Next-state and Mealy output decode; Rst and MemStall override the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    brne_d  = brne_q;
    ctl_s   = OUT_DEF;
    if (Rst) begin
      state_d = NORMAL;
      cnt_d   = 3'd0;
      brne_d  = 1'b0;
      ctl_s   = OUT_DEF;
    end else if (hz.MemStall) begin
      ctl_s = OUT_FRZ;
    end else begin
      case (state_q)
        NORMAL: begin
          if (hz.Jump) begin
            ctl_s   = OUT_JMP;
            state_d = JUMP;
          end else if (ld_hazard_s) begin
            ctl_s   = OUT_HOLD;
            cnt_d   = LD_INIT;
            state_d = LOAD;
          end else if (hz.Branch) begin
            ctl_s   = OUT_BRH;
            cnt_d   = BR_INIT;
            brne_d  = hz.BranchNe;
            state_d = BR_WAIT;
          end else begin
            ctl_s   = OUT_DEF;
            state_d = NORMAL;
          end
        end
        LOAD: begin
          if (cnt_q != 3'd0) begin
            ctl_s = OUT_HOLD;
            cnt_d = cnt_q - 3'd1;
          end else begin
            ctl_s   = OUT_DEF;
            state_d = NORMAL;
          end
        end
        BR_WAIT: begin
          // brne flips the sense of ALUZero so beq and bne share one path
          if (cnt_q != 3'd0) begin
            ctl_s = OUT_HOLD;
            cnt_d = cnt_q - 3'd1;
          end else if (hz.ALUZero ^ brne_q) begin
            ctl_s   = OUT_TKN;
            state_d = BR_TAKEN;
          end else begin
            ctl_s   = OUT_DEF;
            state_d = NORMAL;
          end
        end
        BR_TAKEN, JUMP: begin
          ctl_s   = OUT_DEF;
          state_d = NORMAL;
        end
        default: begin
          ctl_s   = OUT_DEF;
          state_d = NORMAL;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles with PC_write low; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Rst || hz.StatClr) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (!ctl_s[3] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset is folded into the _d logic above.
  always_ff @(posedge Clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    brne_q      <= brne_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign {hz.IF_write, hz.PC_write, hz.bubble, hz.addrSel} = ctl_s;
  assign hz.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Scoreboard bench for hazard_ctrl_param (LOAD_STALLS=3, BR_RESOLVE=2, CNT_W=4):
// each driven cycle pushes its expected outputs; the negedge monitor pops and checks.
module tb_hazard_ctrl_param;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  localparam logic [4:0] E_DEF  = 5'b11000;
  localparam logic [4:0] E_HOLD = 5'b00100;
  localparam logic [4:0] E_BRH  = 5'b10000;
  localparam logic [4:0] E_JMP  = 5'b01101;
  localparam logic [4:0] E_TKN  = 5'b01110;
  localparam logic [4:0] E_FRZ  = 5'b00000;

  typedef struct {
    string      tag;
    logic [4:0] ctl;
    int         sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb_q[$];
  exp_t it;
  int   exp_sc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  hazard_ctrl_param_if #(.REG_W(5), .CNT_W(CNT_W)) hz_if ();

  hazard_ctrl_param #(
    .REG_W(5), .LOAD_STALLS(3), .BR_RESOLVE(2), .CNT_W(CNT_W)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .hz (hz_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push this cycle's expectation, advance the counter model, move to the next cycle.
  task automatic step(input string tag, input logic [4:0] ctl);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.sc  = exp_sc;
    sb_q.push_back(e);
    if (rst || hz_if.StatClr) exp_sc = 0;
    else if (!ctl[3] && exp_sc != SAT) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_if.Jump = 1'b0;      hz_if.Branch = 1'b0;   hz_if.BranchNe = 1'b0;
    hz_if.ALUZero = 1'b0;   hz_if.memReadEX = 1'b0;
    hz_if.currRs = 5'd0;    hz_if.currRt = 5'd0;   hz_if.prevRt = 5'd0;
    hz_if.UseShamt = 1'b0;  hz_if.UseImmed = 1'b0;
    hz_if.MemStall = 1'b0;  hz_if.StatClr = 1'b0;
  endtask

  task automatic set_ld(input logic mr, input logic [4:0] prt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ush, input logic uim);
    hz_if.memReadEX = mr; hz_if.prevRt = prt; hz_if.currRs = rs;
    hz_if.currRt = rt;    hz_if.UseShamt = ush; hz_if.UseImmed = uim;
  endtask

  // Branch sequence: decode, one wait cycle, resolve with z, then follow-up.
  task automatic branch_seq(input string tag, input logic ne, input logic z, input logic taken);
    hz_if.Branch = 1'b1; hz_if.BranchNe = ne; hz_if.ALUZero = ~z;
    step({tag, "_brh"}, E_BRH);
    hz_if.Branch = 1'b0; hz_if.BranchNe = ~ne;
    step({tag, "_hold"}, E_HOLD);
    hz_if.ALUZero = z;
    if (taken) begin
      step({tag, "_tkn"}, E_TKN);
      hz_if.ALUZero = 1'b0;
      step({tag, "_post"}, E_DEF);
    end else begin
      step({tag, "_nt"}, E_DEF);
    end
    hz_if.ALUZero = 1'b0; hz_if.BranchNe = 1'b0;
    step({tag, "_idle"}, E_DEF);
  endtask

  // Monitor: compare popped expectations against the DUT away from the active edge.
  always @(negedge clk) begin
    if (done) begin
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_eq({it.tag, ".ctl"},
               32'({hz_if.IF_write, hz_if.PC_write, hz_if.bubble, hz_if.addrSel}), 32'(it.ctl));
      check_eq({it.tag, ".cnt"}, 32'(hz_if.StallCount), 32'(it.sc));
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("rst0", E_DEF);
    step("rst1", E_DEF);
    rst = 1'b0;
    step("idle", E_DEF);

    // Load-use on Rs: 3 PC-held cycles then DEF, inputs ignored in the final LOAD cycle
    set_ld(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    step("ld_det", E_HOLD);
    step("ld_h1", E_HOLD);
    step("ld_h2", E_HOLD);
    step("ld_end", E_DEF);
    set_ld(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    step("ld_idle", E_DEF);

    // Exclusions: r0, immediate and shamt forms do not read Rt
    set_ld(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("ex_r0", E_DEF);
    set_ld(1'b1, 5'd9, 5'd4, 5'd9, 1'b0, 1'b1);
    step("ex_imm", E_DEF);
    set_ld(1'b1, 5'd9, 5'd4, 5'd9, 1'b1, 1'b0);
    step("ex_shamt", E_DEF);
    set_ld(1'b0, 5'd9, 5'd4, 5'd9, 1'b0, 1'b0);
    step("ex_noload", E_DEF);
    // Rt-path hazard; the counter must keep running after the load leaves EX
    set_ld(1'b1, 5'd9, 5'd4, 5'd9, 1'b0, 1'b0);
    step("rt_det", E_HOLD);
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("rt_h1", E_HOLD);
    step("rt_h2", E_HOLD);
    step("rt_end", E_DEF);

    hz_if.StatClr = 1'b1;
    step("clr", E_DEF);
    hz_if.StatClr = 1'b0;

    branch_seq("beq_t", 1'b0, 1'b1, 1'b1);
    branch_seq("beq_nt", 1'b0, 1'b0, 1'b0);
    branch_seq("bne_t", 1'b1, 1'b0, 1'b1);
    branch_seq("bne_nt", 1'b1, 1'b1, 1'b0);

    // Jump beats a simultaneous load-use and branch; hazard retried afterwards
    hz_if.Jump = 1'b1; hz_if.Branch = 1'b1;
    set_ld(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    step("jmp", E_JMP);
    hz_if.Jump = 1'b0; hz_if.Branch = 1'b0;
    step("jmp_post", E_DEF);
    step("jmp_ld", E_HOLD);
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("jmp_ld_h1", E_HOLD);
    step("jmp_ld_h2", E_HOLD);
    step("jmp_ld_end", E_DEF);

    hz_if.StatClr = 1'b1;
    step("clr2", E_DEF);
    hz_if.StatClr = 1'b0;

    // MemStall inside BR_WAIT: freeze 4 cycles, then resolve as normal
    hz_if.Branch = 1'b1;
    step("ms_brh", E_BRH);
    hz_if.Branch = 1'b0; hz_if.MemStall = 1'b1; hz_if.ALUZero = 1'b1;
    for (int i = 0; i < 4; i++) step("ms_frz", E_FRZ);
    hz_if.MemStall = 1'b0; hz_if.ALUZero = 1'b0;
    step("ms_hold", E_HOLD);
    hz_if.ALUZero = 1'b1;
    step("ms_tkn", E_TKN);
    hz_if.ALUZero = 1'b0;
    step("ms_post", E_DEF);

    // Jump held off by MemStall, then taken
    hz_if.Jump = 1'b1; hz_if.MemStall = 1'b1;
    step("msj_frz", E_FRZ);
    hz_if.MemStall = 1'b0;
    step("msj_jmp", E_JMP);
    hz_if.Jump = 1'b0;
    step("msj_post", E_DEF);

    // Saturation at 15, then clear concurrent with MemStall
    hz_if.MemStall = 1'b1;
    for (int i = 0; i < 20; i++) step("sat", E_FRZ);
    hz_if.StatClr = 1'b1;
    step("sat_clr", E_FRZ);
    hz_if.StatClr = 1'b0; hz_if.MemStall = 1'b0;
    step("sat_after", E_DEF);

    // Reset aborts LOAD
    set_ld(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    step("rl_det", E_HOLD);
    step("rl_h1", E_HOLD);
    rst = 1'b1;
    step("rl_rst", E_DEF);
    rst = 1'b0;
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("rl_after", E_DEF);

    // Reset aborts BR_WAIT (no TKN) and overrides MemStall
    hz_if.Branch = 1'b1;
    step("rb_brh", E_BRH);
    hz_if.Branch = 1'b0; hz_if.ALUZero = 1'b1; hz_if.MemStall = 1'b1;
    rst = 1'b1;
    step("rb_rst", E_DEF);
    rst = 1'b0; hz_if.MemStall = 1'b0;
    step("rb_after", E_DEF);
    hz_if.ALUZero = 1'b0;
    step("rb_idle", E_DEF);

    done = 1'b1;
  end

endmodule
